ram_loader: RTL

- Upstream feeder of the system RAM. Accepts a byte stream from the MiST ioctl download channel, a PRG-style image (2-byte little-endian load address, then payload), and writes it into RAM.
- Holds the CPU off the bus while loading and multiplexes the RAM address, din and w_en between the CPU and the loader.
- Reports load status and end address to the rest of the core.

---
 rtl/ram_loader_pkg.sv | 16 +
 rtl/ram_bus_mux.sv | 23 ++
 rtl/ram_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ram_loader_pkg.sv
// Shared definitions for the ram_loader slice: FSM states and default geometry.
package ram_loader_pkg;

    localparam int unsigned ADDR_W_DEF   = 16;
    localparam int unsigned RAM_SIZE_DEF = 49152;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        DATA,
        DRAIN,
        DONE
    } ld_state_t;

endpackage

// File: rtl/ram_bus_mux.sv
// Combinational RAM bus select: CPU owns the bus when idle, the loader while busy.
module ram_bus_mux
    import ram_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              busy,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_w_en,
    input  logic [7:0]        cpu_dout,
    input  logic [ADDR_W-1:0] ldr_address,
    input  logic              ldr_w_en,
    input  logic [7:0]        ldr_din,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_w_en,
    output logic [7:0]        ram_din
);

    assign ram_address = busy ? ldr_address : cpu_address;
    assign ram_w_en    = busy ? ldr_w_en    : cpu_w_en;
    assign ram_din     = busy ? ldr_din     : cpu_dout;

endmodule

// File: rtl/ram_loader.sv
// Loads a PRG-style image (LE load address, then payload) from the ioctl stream into RAM.
// Optional RAM_LOADER_AUTOSTART_EN adds run_addr and cpu_reset_req outputs.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int unsigned RAM_SIZE = RAM_SIZE_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dl_active,
    input  logic              dl_valid,
    input  logic [7:0]        dl_data,
    output logic              dl_ready,
    input  logic              wr_slot,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_w_en,
    input  logic [7:0]        cpu_dout,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_w_en,
    output logic [7:0]        ram_din,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] end_addr
`ifdef RAM_LOADER_AUTOSTART_EN
    ,
    output logic [ADDR_W-1:0] run_addr,
    output logic              cpu_reset_req
`endif
);

    ld_state_t         state;
    logic              dl_active_q;
    logic              pending;
    logic [7:0]        hold_byte;
    logic [7:0]        addr_lo;
    logic [ADDR_W-1:0] wr_ptr;
    logic              in_range;
    logic              slot_write;
    logic              ldr_w_en;
    logic              enter_done;

    assign in_range   = (32'(wr_ptr) < RAM_SIZE);
    assign slot_write = pending && wr_slot && (state == DATA || state == DRAIN);
    assign ldr_w_en   = slot_write && in_range;
    // pending blocks acceptance, so a write cycle can never also take a byte
    assign dl_ready   = (state == ADDR_LO) || (state == ADDR_HI) || (state == DATA && !pending);
    assign enter_done = ((state == ADDR_LO || state == ADDR_HI) && !dl_active)
                     || (state == DRAIN && !pending);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dl_active_q <= 1'b0;
            pending     <= 1'b0;
            hold_byte   <= '0;
            addr_lo     <= '0;
            wr_ptr      <= '0;
            busy        <= 1'b0;
            cpu_hold    <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            end_addr    <= '0;
`ifdef RAM_LOADER_AUTOSTART_EN
            run_addr      <= '0;
            cpu_reset_req <= 1'b0;
`endif
        end else begin
            dl_active_q <= dl_active;
            done        <= 1'b0;
`ifdef RAM_LOADER_AUTOSTART_EN
            cpu_reset_req <= 1'b0;
`endif
            // Out-of-range bytes are consumed and still advance the pointer.
            if (slot_write) begin
                pending  <= 1'b0;
                wr_ptr   <= wr_ptr + 1'b1;
                end_addr <= wr_ptr + 1'b1;
                if (!in_range) overflow <= 1'b1;
            end

            if (enter_done) begin
                state    <= DONE;
                done     <= 1'b1;
                busy     <= 1'b0;
                cpu_hold <= 1'b0;
`ifdef RAM_LOADER_AUTOSTART_EN
                cpu_reset_req <= !overflow;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (dl_active && !dl_active_q) begin
                            state    <= ADDR_LO;
                            overflow <= 1'b0;
                            busy     <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                    ADDR_LO: begin
                        if (dl_valid) begin
                            addr_lo <= dl_data;
                            state   <= ADDR_HI;
                        end
                    end
                    ADDR_HI: begin
                        if (dl_valid) begin
                            wr_ptr <= ADDR_W'({dl_data, addr_lo});
`ifdef RAM_LOADER_AUTOSTART_EN
                            run_addr <= ADDR_W'({dl_data, addr_lo});
`endif
                            state  <= DATA;
                        end
                    end
                    DATA: begin
                        if (dl_valid && !pending) begin
                            hold_byte <= dl_data;
                            pending   <= 1'b1;
                        end
                        if (!dl_active) state <= DRAIN;
                    end
                    DRAIN:   state <= DRAIN;
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    ram_bus_mux #(
        .ADDR_W(ADDR_W)
    ) u_bus_mux (
        .busy        (busy),
        .cpu_address (cpu_address),
        .cpu_w_en    (cpu_w_en),
        .cpu_dout    (cpu_dout),
        .ldr_address (wr_ptr),
        .ldr_w_en    (ldr_w_en),
        .ldr_din     (hold_byte),
        .ram_address (ram_address),
        .ram_w_en    (ram_w_en),
        .ram_din     (ram_din)
    );

endmodule
